useq_sequencer: RTL
===================

Name: useq_sequencer

Overview:
- Parametrised microcode sequencer that generates the micro-address for the control-store ROM bank.
- Registers the fetched control word into the execution pipeline register.
- Extends the fixed 14-byte, 7-bit-offset scheme with configurable ROM byte count, micro-address width and condition bank size.
- Adds a micro-subroutine call/return stack.
- Sits between the control-store ROMs and the datapath. Feeds the datapath the control word, and takes IR opcode and status/micro flags back.

Parameters:
- ROM_BYTES, 14: number of 8-bit control ROMs; control word width = 8*ROM_BYTES (>=3).
- SLOT_BITS, 6: micro-steps per opcode slot (log2); UADDR_W = 8 + SLOT_BITS.
- COND_BANK, 16: conditions per flag bank; two banks, selected by the flag_src bit.
- STACK_DEPTH, 4: micro-return stack entries (1..8).
- RESET_VEC, 0: micro-address loaded on reset and on stack underflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  high = hold all state this cycle.
- ir_opcode  in  8  current instruction register value.
- cond_flags  in  2*COND_BANK  bank0 in [COND_BANK-1:0], bank1 above it.
- u_rom_data  in  8*ROM_BYTES  combinational ROM read of u_addr.
- u_addr  out  UADDR_W  registered micro-address to ROMs.
- ctrl_word  out  8*ROM_BYTES  registered control word to datapath.
- branch_taken  out  1  registered; 1 when the last advance left the sequential path.
- stack_overflow  out  1  sticky error flag.
- stack_underflow  out  1  sticky error flag.

Behaviour:
- Field decode from u_rom_data (w):
  - typ = w[1:0]
  - offset = w[8:2], 7-bit two's complement, sign-extended to UADDR_W
  - cond_invert = w[9]
  - flag_src = w[10]
  - cond_sel = w[14:11]
  - escape = w[15]
  - cond = cond_flags[flag_src*COND_BANK + cond_sel] XOR cond_invert
  - cond_sel indices >= COND_BANK read as 0 (before invert).
- Next-address rules, all additions modulo 2^UADDR_W (0x3FFF+1 wraps to 0x0000):
  - typ 00 NEXT: u_addr+1.
  - typ 01 BRANCH: cond ? u_addr+offset : u_addr+1.
  - typ 10 DISPATCH: {ir_opcode, SLOT_BITS'0}; escape=1 instead gives {ir_opcode, SLOT_BITS'0} + (1<<(SLOT_BITS-1)), selecting the upper half-slot.
  - typ 11, escape=0, CALL: push u_addr+1, then jump to u_addr+offset.
  - typ 11, escape=1, RETURN: pop into u_addr.
- branch_taken = 1 for BRANCH with cond=1, DISPATCH, CALL and RETURN; 0 otherwise.
- Each non-stalled cycle: u_addr <= next; ctrl_word <= u_rom_data; branch_taken updated. Latency: ROM word at u_addr appears on ctrl_word one cycle later.
- stall=1: u_addr, ctrl_word, stack, pointer, branch_taken and flags all held; cond_flags ignored.
- Stack is LIFO; pointer sp runs 0..STACK_DEPTH.
  - CALL with sp==STACK_DEPTH: no push, jump still taken, stack_overflow<=1.
  - RETURN with sp==0: u_addr<=RESET_VEC, stack_underflow<=1.
  - Error flags are sticky until rst.
- Reset, synchronous, dominates stall:
  - u_addr=RESET_VEC
  - ctrl_word=0 (decodes as NEXT/no-op)
  - branch_taken=0
  - sp=0, stack contents don't-care
  - stack_overflow=0, stack_underflow=0
  - rst asserted mid-subroutine discards the stack; the next cycle after rst deassert fetches RESET_VEC.

Test Plan:
- Reset then NEXT words: rst 2 cycles -> u_addr=0x0000, ctrl_word=0. Release with ROM all-NEXT -> u_addr 1,2,3; ctrl_word lags u_addr by one cycle.
- Branch both polarities at u_addr=0x0040, offset=-4 (0x7C), cond_sel=3, flag_src=1:
  - cond_flags[19]=1, invert=0 -> 0x003C, branch_taken=1.
  - invert=1 -> 0x0041, branch_taken=0.
- Dispatch: ir_opcode=0xA5, typ 10 -> u_addr=0x2940; escape=1 -> 0x2960.
- Call/return nesting, STACK_DEPTH=4:
  - 5 nested CALLs -> stack_overflow=1 on the 5th, jump still taken.
  - 4 RETURNs -> addresses return in LIFO order.
  - 5th RETURN -> u_addr=RESET_VEC, stack_underflow=1.
- Stall and wrap: stall=1 for 3 cycles mid-branch -> all outputs frozen despite cond_flags toggling. NEXT at 0x3FFF -> 0x0000.
- rst during stall with sp=2 -> one cycle later u_addr=0, sp=0, flags clear.

Source files
------------

// File: rtl/useq_sequencer.sv
// Microcode sequencer: forms the next control-store address from the fetched word,
// registers the control word for the datapath, and keeps a micro-subroutine stack.
module useq_sequencer #(
    parameter int ROM_BYTES   = 14,
    parameter int SLOT_BITS   = 6,
    parameter int COND_BANK   = 16,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_VEC   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [7:0]                 ir_opcode,
    input  logic [2*COND_BANK-1:0]     cond_flags,
    input  logic [8*ROM_BYTES-1:0]     u_rom_data,
    output logic [8+SLOT_BITS-1:0]     u_addr,
    output logic [8*ROM_BYTES-1:0]     ctrl_word,
    output logic                       branch_taken,
    output logic                       stack_overflow,
    output logic                       stack_underflow
);

    localparam int UADDR_W = 8 + SLOT_BITS;
    localparam int IDX_W   = $clog2(2 * COND_BANK);
    localparam int SP_W    = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        OP_NEXT     = 2'b00,
        OP_BRANCH   = 2'b01,
        OP_DISPATCH = 2'b10,
        OP_CALLRET  = 2'b11
    } op_t;

    function automatic logic signed [UADDR_W-1:0] sext_offset(input logic [6:0] raw);
        return {{(UADDR_W-7){raw[6]}}, raw};
    endfunction

    logic [UADDR_W-1:0]        stack [0:(1<<PTR_W)-1];
    logic [SP_W-1:0]           sp;

    op_t                       op;
    logic signed [UADDR_W-1:0] offset;
    logic [3:0]                cond_sel;
    logic [IDX_W-1:0]          cond_idx;
    logic                      cond_raw;
    logic                      cond;
    logic                      escape;
    logic [UADDR_W-1:0]        seq_addr;
    logic [UADDR_W-1:0]        slot_base;
    logic [UADDR_W-1:0]        next_addr;
    logic                      next_taken;
    logic                      do_push;
    logic                      do_pop;
    logic                      set_ovf;
    logic                      set_unf;

    always_comb begin
        op         = op_t'(u_rom_data[1:0]);
        offset     = sext_offset(u_rom_data[8:2]);
        cond_sel   = u_rom_data[14:11];
        escape     = u_rom_data[15];
        cond_idx   = IDX_W'(int'(u_rom_data[10]) * COND_BANK + int'(cond_sel));
        cond_raw   = 1'b0;
        if (int'(cond_sel) < COND_BANK)
            cond_raw = cond_flags[cond_idx];
        cond       = cond_raw ^ u_rom_data[9];
        seq_addr   = u_addr + UADDR_W'(1);
        slot_base  = {ir_opcode, {SLOT_BITS{1'b0}}};

        next_addr  = seq_addr;
        next_taken = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;

        case (op)
            OP_BRANCH: begin
                if (cond) begin
                    next_addr  = u_addr + offset;
                    next_taken = 1'b1;
                end
            end
            OP_DISPATCH: begin
                // Escape selects the upper half of the opcode's slot.
                next_addr  = slot_base + (escape ? (UADDR_W'(1) << (SLOT_BITS - 1)) : '0);
                next_taken = 1'b1;
            end
            OP_CALLRET: begin
                next_taken = 1'b1;
                if (!escape) begin
                    next_addr = u_addr + offset;
                    if (sp == SP_W'(STACK_DEPTH)) set_ovf = 1'b1;
                    else                          do_push = 1'b1;
                end else if (sp == '0) begin
                    next_addr = UADDR_W'(RESET_VEC);
                    set_unf   = 1'b1;
                end else begin
                    next_addr = stack[PTR_W'(sp - SP_W'(1))];
                    do_pop    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Fetch/execute register boundary: address, control word and stack advance together.
    always_ff @(posedge clk) begin
        if (rst) begin
            u_addr          <= UADDR_W'(RESET_VEC);
            ctrl_word       <= '0;
            branch_taken    <= 1'b0;
            sp              <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (!stall) begin
            u_addr       <= next_addr;
            ctrl_word    <= u_rom_data;
            branch_taken <= next_taken;
            if (do_push) sp <= sp + SP_W'(1);
            if (do_pop)  sp <= sp - SP_W'(1);
            if (set_ovf) stack_overflow  <= 1'b1;
            if (set_unf) stack_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !stall && do_push)
            stack[PTR_W'(sp)] <= seq_addr;
    end

endmodule
